load_store_unit: RTL and testbench

- Sits between the execute stage and `data_memory`.
- Accepts one load or store request at a time, in RISC-V RV32I byte/halfword/word form.
- Translates byte addresses to word indices and sign- or zero-extends load data.
- Memory is word-wide with no byte enables, so sub-word stores use a read-modify-write sequence.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_lane_align.sv | 59 +++++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and request-legality helpers used when a request is accepted.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_STORE,
        S_RESP
    } lsu_state_t;

    // Stores only come in signed-width form; loads also have unsigned variants.
    function automatic logic f3Legal(input logic isWrite, input logic [2:0] f3);
        logic legal;
        legal = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !isWrite;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic f3Aligned(input logic [2:0] f3, input logic [1:0] addrLo);
        logic ok;
        ok = 1'b1;
        case (f3)
            F3_H, F3_HU: ok = (addrLo[0] == 1'b0);
            F3_W:        ok = (addrLo == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extracts and extends load data from a memory
// word, and merges sub-word store data into the word read back from memory.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane, then extend it or splice store data into it.
    always_comb begin
        w_byte        = i_mem_word[7:0];
        w_half        = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];
        o_load_data   = i_mem_word;
        o_merged_word = i_mem_word;

        case (i_addr_lo)
            2'd0:    w_byte = i_mem_word[7:0];
            2'd1:    w_byte = i_mem_word[15:8];
            2'd2:    w_byte = i_mem_word[23:16];
            default: w_byte = i_mem_word[31:24];
        endcase

        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = i_mem_word;
        endcase

        case (i_funct3)
            F3_B: begin
                case (i_addr_lo)
                    2'd0:    o_merged_word[7:0]   = i_store_data[7:0];
                    2'd1:    o_merged_word[15:8]  = i_store_data[7:0];
                    2'd2:    o_merged_word[23:16] = i_store_data[7:0];
                    default: o_merged_word[31:24] = i_store_data[7:0];
                endcase
            end
            F3_H: begin
                if (i_addr_lo[1]) begin
                    o_merged_word[31:16] = i_store_data[15:0];
                end else begin
                    o_merged_word[15:0] = i_store_data[15:0];
                end
            end
            default: o_merged_word = i_store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between execute and a word-wide data memory without
// byte enables. Sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_mem_addr;
    logic [31:0] r_wbuf;
    logic [31:0] r_rdata;
    logic        r_error;

    logic        w_accept;
    logic        w_in_range;
    logic        w_error;
    logic [31:0] w_load_data;
    logic [31:0] w_merged_word;

    assign w_accept   = req_valid && req_ready;
    assign w_in_range = ({2'b00, req_addr[31:2]} < 32'(MEM_WORDS));
    assign w_error    = !f3Legal(req_write, req_funct3)
                     || !f3Aligned(req_funct3, req_addr[1:0])
                     || !w_in_range;

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign mem_read   = !rst && ((r_state == S_LOAD) || (r_state == S_RMW_RD));
    assign mem_write  = !rst && (r_state == S_STORE);
    assign resp_valid = !rst && (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_error = r_error;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_wbuf;

    // The write buffer holds raw store data until the RMW read merges it.
    lsu_lane_align u_lane_align (
        .i_funct3      (r_funct3),
        .i_addr_lo     (r_addr_lo),
        .i_mem_word    (mem_rdata),
        .i_store_data  (r_wbuf),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged_word)
    );

    // Request FSM: latch at acceptance, access memory, then pulse the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_funct3   <= 3'b000;
            r_addr_lo  <= 2'b00;
            r_mem_addr <= 32'h0;
            r_wbuf     <= 32'h0;
            r_rdata    <= 32'h0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        r_wbuf    <= req_wdata;
                        r_rdata   <= 32'h0;
                        r_error   <= w_error;
                        if (w_error) begin
                            r_state <= S_RESP;
                        end else begin
                            r_mem_addr <= {2'b00, req_addr[31:2]};
                            if (!req_write) begin
                                r_state <= S_LOAD;
                            end else if (req_funct3 == F3_W) begin
                                r_state <= S_STORE;
                            end else begin
                                r_state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_rdata <= w_load_data;
                    r_state <= S_RESP;
                end
                S_RMW_RD: begin
                    r_wbuf  <= w_merged_word;
                    r_state <= S_STORE;
                end
                S_STORE: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide memory model attached.
module tb_load_store_unit;

    localparam int MEM_WORDS = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:MEM_WORDS-1];
    int          wrPulses;
    int          rdCycles;
    logic [31:0] lastWrAddr;

    int vectors;
    int miscompares;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational read port of the memory model.
    assign mem_rdata = (mem_addr < 32'(MEM_WORDS)) ? mem[mem_addr[9:0]] : 32'h0;

    // Memory write port plus counters of write pulses and read cycles.
    always @(posedge clk) begin
        if (mem_write) begin
            wrPulses   <= wrPulses + 1;
            lastWrAddr <= mem_addr;
            if (mem_addr < 32'(MEM_WORDS)) begin
                mem[mem_addr[9:0]] <= mem_wdata;
            end
        end
        if (mem_read) begin
            rdCycles <= rdCycles + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request from IDLE and collect its response and memory activity.
    task automatic applyStimulus(input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err,
                                 output int lat, output int nWr, output int nRd);
        int wr0;
        int rd0;
        @(negedge clk);
        checkOutput("ready before request", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        wr0 = wrPulses;
        rd0 = rdCycles;
        @(posedge clk);
        lat   = 0;
        rdata = 32'h0;
        err   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            req_funct3 = 3'b111;
            req_addr   = 32'hFFFF_FFFF;
            req_wdata  = 32'h0;
            if (resp_valid) begin
                lat   = i;
                rdata = resp_rdata;
                err   = resp_error;
                break;
            end
        end
        nWr = wrPulses - wr0;
        nRd = rdCycles - rd0;
    endtask

    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nWr;
    int          nRd;

    task automatic doStore(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int expLat,
                           input logic [31:0] expWrAddr);
        applyStimulus(1'b1, f3, addr, wdata, rdata, err, lat, nWr, nRd);
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " write pulses"}, 32'(nWr), 32'd1);
        checkOutput({tag, " write addr"}, lastWrAddr, expWrAddr);
        checkOutput({tag, " error"}, {31'h0, err}, 32'h0);
        checkOutput({tag, " rdata"}, rdata, 32'h0);
    endtask

    task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] expData);
        applyStimulus(1'b0, f3, addr, 32'h0, rdata, err, lat, nWr, nRd);
        checkOutput({tag, " latency"}, 32'(lat), 32'd2);
        checkOutput({tag, " data"}, rdata, expData);
        checkOutput({tag, " error"}, {31'h0, err}, 32'h0);
        checkOutput({tag, " writes"}, 32'(nWr), 32'd0);
    endtask

    typedef struct {
        string       tag;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
    } errVec_t;

    errVec_t errVecs [5];
    logic [31:0] b2bAddr [3];
    logic [31:0] b2bData [3];

    initial begin
        vectors     = 0;
        miscompares = 0;
        wrPulses    = 0;
        rdCycles    = 0;
        lastWrAddr  = 32'h0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        checkOutput("reset resp_error", {31'h0, resp_error}, 32'h0);
        checkOutput("reset mem_read", {31'h0, mem_read}, 32'h0);
        checkOutput("reset mem_write", {31'h0, mem_write}, 32'h0);
        checkOutput("reset resp_rdata", resp_rdata, 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        // Full-word store and load.
        doStore("SW 0x10", 3'b010, 32'h10, 32'hDEAD_BEEF, 2, 32'd4);
        checkOutput("mem[4] after SW", mem[4], 32'hDEAD_BEEF);
        doLoad("LW 0x10", 3'b010, 32'h10, 32'hDEAD_BEEF);

        // Byte merge into word 4, then signed and unsigned byte loads.
        doStore("SW seed w4", 3'b010, 32'h10, 32'h1122_3344, 2, 32'd4);
        doStore("SB 0x12", 3'b000, 32'h12, 32'hFFFF_FFAB, 3, 32'd4);
        checkOutput("SB read cycles", 32'(nRd), 32'd1);
        checkOutput("mem[4] after SB", mem[4], 32'h11AB_3344);
        doLoad("LB 0x12", 3'b000, 32'h12, 32'hFFFF_FFAB);
        doLoad("LBU 0x12", 3'b100, 32'h12, 32'h0000_00AB);
        doLoad("LBU 0x13", 3'b100, 32'h13, 32'h0000_0011);

        // Upper halfword merge into word 5, then extension checks.
        doStore("SW seed w5", 3'b010, 32'h14, 32'h5555_AAAA, 2, 32'd5);
        doStore("SH 0x16", 3'b001, 32'h16, 32'h1234_8001, 3, 32'd5);
        checkOutput("mem[5] after SH", mem[5], 32'h8001_AAAA);
        doLoad("LH 0x16", 3'b001, 32'h16, 32'hFFFF_8001);
        doLoad("LHU 0x16", 3'b101, 32'h16, 32'h0000_8001);
        doLoad("LH 0x14", 3'b001, 32'h14, 32'hFFFF_AAAA);

        // Error cases respond one cycle after acceptance with no memory access.
        errVecs[0] = '{"LW misaligned", 1'b0, 3'b010, 32'h13};
        errVecs[1] = '{"LH misaligned", 1'b0, 3'b001, 32'h11};
        errVecs[2] = '{"funct3 011", 1'b0, 3'b011, 32'h10};
        errVecs[3] = '{"LW out of range", 1'b0, 3'b010, 32'(4 * MEM_WORDS)};
        errVecs[4] = '{"SBU illegal", 1'b1, 3'b100, 32'h10};
        foreach (errVecs[i]) begin
            applyStimulus(errVecs[i].wr, errVecs[i].f3, errVecs[i].addr, 32'h5A5A_5A5A,
                          rdata, err, lat, nWr, nRd);
            checkOutput({errVecs[i].tag, " error"}, {31'h0, err}, 32'h1);
            checkOutput({errVecs[i].tag, " latency"}, 32'(lat), 32'd1);
            checkOutput({errVecs[i].tag, " rdata"}, rdata, 32'h0);
            checkOutput({errVecs[i].tag, " writes"}, 32'(nWr), 32'd0);
            checkOutput({errVecs[i].tag, " reads"}, 32'(nRd), 32'd0);
        end
        checkOutput("mem[4] after errors", mem[4], 32'h11AB_3344);

        // Reset during the read half of a byte store drops it entirely.
        doStore("SW seed w8", 3'b010, 32'h20, 32'hCAFE_F00D, 2, 32'd8);
        begin
            int wr0;
            @(negedge clk);
            req_valid  = 1'b1;
            req_write  = 1'b1;
            req_funct3 = 3'b000;
            req_addr   = 32'h20;
            req_wdata  = 32'h77;
            wr0 = wrPulses;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            checkOutput("RMW_RD mem_read", {31'h0, mem_read}, 32'h1);
            rst = 1'b1;
            #1;
            checkOutput("mem_read gated by rst", {31'h0, mem_read}, 32'h0);
            @(negedge clk);
            checkOutput("rst ready low", {31'h0, req_ready}, 32'h0);
            checkOutput("rst mem_write", {31'h0, mem_write}, 32'h0);
            checkOutput("rst resp_valid", {31'h0, resp_valid}, 32'h0);
            rst = 1'b0;
            @(negedge clk);
            checkOutput("post-rst ready", {31'h0, req_ready}, 32'h1);
            checkOutput("post-rst resp_valid", {31'h0, resp_valid}, 32'h0);
            @(negedge clk);
            checkOutput("post-rst resp_valid late", {31'h0, resp_valid}, 32'h0);
            checkOutput("dropped store writes", 32'(wrPulses - wr0), 32'd0);
            checkOutput("mem[8] untouched", mem[8], 32'hCAFE_F00D);
        end
        doLoad("LW 0x20", 3'b010, 32'h20, 32'hCAFE_F00D);

        // Back-to-back loads with req_valid held continuously.
        b2bAddr[0] = 32'h10; b2bData[0] = 32'h11AB_3344;
        b2bAddr[1] = 32'h14; b2bData[1] = 32'h8001_AAAA;
        b2bAddr[2] = 32'h20; b2bData[2] = 32'hCAFE_F00D;
        begin
            int accepted;
            int responses;
            logic took;
            accepted  = 0;
            responses = 0;
            @(negedge clk);
            req_valid  = 1'b1;
            req_write  = 1'b0;
            req_funct3 = 3'b010;
            req_addr   = b2bAddr[0];
            for (int c = 0; c < 12; c++) begin
                if (resp_valid) begin
                    if (responses < 3) begin
                        checkOutput("b2b data", resp_rdata, b2bData[responses]);
                    end
                    responses++;
                end
                took = req_ready && req_valid;
                if (took) begin
                    checkOutput("b2b accept cycle", 32'(c), 32'(3 * accepted));
                    accepted++;
                end
                @(posedge clk);
                @(negedge clk);
                if (took) begin
                    if (accepted < 3) begin
                        req_addr = b2bAddr[accepted];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
            end
            checkOutput("b2b accepted count", 32'(accepted), 32'd3);
            checkOutput("b2b response count", 32'(responses), 32'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the bench always ends even if the design stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
